// File: rtl/strobe_uart_pkg.sv
// Shared types and width helpers for the strobe-fed UART transmitter.
package strobe_uart_pkg;

    // Transmitter frame phases.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Defaults shared by the top and the FIFO.
    localparam int unsigned DEF_DATA_W       = 8;
    localparam int unsigned DEF_DEPTH        = 8;
    localparam int unsigned DEF_CLKS_PER_BIT = 16;

    // Width of an index that counts 0..n-1 (never narrower than one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of an occupancy count that must reach n itself.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/strobe_fifo.sv
// Register-array FIFO with occupancy count; a write into a full FIFO is
// accepted only when a pop happens in the same cycle.
module strobe_fifo
    import strobe_uart_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_en,
    output logic [DATA_W-1:0]         rd_data,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      full
);

    localparam int unsigned PTR_W = idx_w(DEPTH);
    localparam int unsigned CNT_W = cnt_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              accept;
    logic              pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign accept  = wr_en && (!full || rd_en);
    assign pop     = rd_en && (count != '0);
    assign rd_data = mem[rd_ptr];

    // Storage array: written on every accepted strobe, no reset needed.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks net change.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/strobe_uart_tx.sv
// 8N1-style UART transmitter fed by single-cycle write strobes through a FIFO.
module strobe_uart_tx
    import strobe_uart_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned DEPTH        = DEF_DEPTH,
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      strobe_in,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      clr_ovf,
    output logic                      txd,
    output logic                      busy,
    output logic [cnt_w(DEPTH)-1:0]   fifo_count,
    output logic                      overflow
);

    localparam int unsigned BAUD_W = idx_w(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = idx_w(DATA_W);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    tx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              txd_q, txd_d;
    logic              ovf_q;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              baud_last;
    logic              drop;
    logic [DATA_W-1:0] rd_data;

    strobe_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (strobe_in),
        .wr_data (data_in),
        .rd_en   (pop),
        .rd_data (rd_data),
        .count   (fifo_count),
        .full    (fifo_full)
    );

    assign fifo_empty = (fifo_count == '0);
    assign baud_last  = (baud_q == BAUD_LAST);
    assign drop       = strobe_in && fifo_full && !pop;
    assign txd        = txd_q;
    assign overflow   = ovf_q;
    assign busy       = (state_q != IDLE) || !fifo_empty;

    // Frame state, counters, shifter and registered line output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    // Next-state logic; txd_d is the value the line takes in the next cycle,
    // and the shifter is pre-shifted so txd_d is always taken from bit 0.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                txd_d  = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = rd_data;
                    txd_d   = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        txd_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    bit_d  = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = rd_data;
                        txd_d   = 1'b0;
                        state_d = START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_strobe_uart_tx.sv
// Self-checking bench: queue-based reference model plus directed and random stimulus.
module tb_strobe_uart_tx;

    localparam int DW    = 8;
    localparam int DEP   = 4;
    localparam int CPB   = 4;
    localparam int FRAME = CPB * (DW + 2);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       strobe_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       clr_ovf = 1'b0;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    strobe_uart_tx #(
        .DATA_W       (DW),
        .DEPTH        (DEP),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .strobe_in  (strobe_in),
        .data_in    (data_in),
        .clr_ovf    (clr_ovf),
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a queue of characters plus one frame whose position
    // 0..FRAME-1 maps to start bit, data bits LSB first, and stop bit.
    logic [7:0] mq[$];
    logic       m_act  = 1'b0;
    int         m_pos  = 0;
    logic [7:0] m_cur  = 8'h00;
    logic       m_ovf  = 1'b0;
    logic       m_live = 1'b0;

    function automatic logic exp_txd();
        if (!m_act)               return 1'b1;
        if (m_pos < CPB)          return 1'b0;
        if (m_pos < CPB * (DW+1)) return m_cur[(m_pos - CPB) / CPB];
        return 1'b1;
    endfunction

    always @(posedge clk) begin : model
        logic pop_m;
        logic wr_m;
        cyc++;
        if (rst) begin
            mq.delete();
            m_act  = 1'b0;
            m_pos  = 0;
            m_ovf  = 1'b0;
            m_live = 1'b1;
        end else begin
            pop_m = (mq.size() != 0) && (!m_act || m_pos == FRAME - 1);
            wr_m  = strobe_in && (mq.size() < DEP || pop_m);
            if (pop_m) begin
                m_cur = mq.pop_front();
                m_act = 1'b1;
                m_pos = 0;
            end else if (m_act) begin
                if (m_pos == FRAME - 1) m_act = 1'b0;
                else                    m_pos++;
            end
            if (wr_m) mq.push_back(data_in);
            if (strobe_in && !wr_m) m_ovf = 1'b1;
            else if (clr_ovf)       m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("m_txd",      int'(txd),        int'(exp_txd()));
            chk("m_busy",     int'(busy),       int'(m_act || mq.size() != 0));
            chk("m_count",    int'(fifo_count), mq.size());
            chk("m_overflow", int'(overflow),   int'(m_ovf));
        end
    end

    // Apply inputs for one cycle and return at the following falling edge.
    task automatic tick(input logic s, input logic [7:0] d, input logic c, input logic r);
        strobe_in = s;
        data_in   = d;
        clr_ovf   = c;
        rst       = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    int unsigned now;
    int exp_a5 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

    initial begin
        @(negedge clk);
        // Reset with strobe held high: strobes must be ignored.
        for (int unsigned c = 0; c < 3; c++) tick(1'b1, 8'hFF, 1'b0, 1'b1);
        chk("rst_txd",   int'(txd), 1);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_ovf",   int'(overflow), 0);

        // Single 0xA5 strobe at cycle 10.
        for (int unsigned c = 0; c <= 60; c++) begin
            tick(c == 10, 8'hA5, 1'b0, 1'b0);
            now = c + 1;
            if (now == 11) chk("a5_pre_start", int'(txd), 1);
            if (now == 12) chk("a5_start", int'(txd), 0);
            if (now >= 16 && now < 48 && (now - 16) % 4 == 2)
                chk("a5_bit", int'(txd), exp_a5[(now - 16) / 4]);
            if (now == 48) chk("a5_stop", int'(txd), 1);
            if (now == 51) chk("a5_busy_end", int'(busy), 1);
            if (now == 52) chk("a5_idle_busy", int'(busy), 0);
        end

        // Three consecutive strobes -> back-to-back frames at 12, 52, 92.
        for (int unsigned c = 0; c <= 132; c++) begin
            tick(c >= 10 && c <= 12, 8'(c - 9), 1'b0, 1'b0);
            now = c + 1;
            if (now == 51)  chk("b2b_stop1",   int'(txd), 1);
            if (now == 52)  chk("b2b_start2",  int'(txd), 0);
            if (now == 61)  chk("b2b_f2_bit1", int'(txd), 1);
            if (now == 91)  chk("b2b_stop2",   int'(txd), 1);
            if (now == 92)  chk("b2b_start3",  int'(txd), 0);
            if (now == 97)  chk("b2b_f3_bit0", int'(txd), 1);
            if (now == 105) chk("b2b_f3_bit2", int'(txd), 0);
            if (now == 131) chk("b2b_busy",    int'(busy), 1);
            if (now == 132) chk("b2b_idle",    int'(busy), 0);
        end

        // Six strobes, overflow, clear, full+pop write, then reset mid-frame.
        for (int unsigned c = 0; c <= 260; c++) begin
            if (c >= 10 && c <= 15)
                tick(1'b1, 8'(8'h10 + c - 10), 1'b0, 1'b0);
            else if (c == 51)
                tick(1'b1, 8'h77, 1'b0, 1'b0);
            else
                tick(1'b0, 8'h00, c == 18, c == 149);
            now = c + 1;
            if (now == 16) chk("ovf_set",       int'(overflow), 1);
            if (now == 16) chk("ovf_count",     int'(fifo_count), 4);
            if (now == 18) chk("ovf_sticky",    int'(overflow), 1);
            if (now == 19) chk("ovf_cleared",   int'(overflow), 0);
            if (now == 52) chk("fullpop_count", int'(fifo_count), 4);
            if (now == 52) chk("fullpop_ovf",   int'(overflow), 0);
            if (now == 52) chk("fullpop_start", int'(txd), 0);
            if (now == 149) chk("prerst_count", int'(fifo_count), 2);
            if (now == 149) chk("prerst_bit3",  int'(txd), 0);
            if (now == 150) chk("rst_mid_txd",   int'(txd), 1);
            if (now == 150) chk("rst_mid_count", int'(fifo_count), 0);
            if (now == 150) chk("rst_mid_busy",  int'(busy), 0);
            if (now > 150 && now % 10 == 0) chk("post_rst_quiet", int'(txd), 1);
        end

        // Randomised traffic, clears and occasional resets.
        for (int unsigned c = 0; c < 4000; c++) begin
            tick($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 40 : 3),
                 8'($urandom), $urandom_range(0, 49) == 0, $urandom_range(0, 799) == 0);
        end
        for (int unsigned c = 0; c < 3 * FRAME; c++) tick(1'b0, 8'h00, 1'b0, 1'b0);
        chk("final_idle", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
